// File: rtl/rs_adder_station_pkg.sv
`default_nettype none
// =============================================================================
// rs_adder_station_pkg -- shared row record, row states and tag helpers
// Rev 1.0
// =============================================================================
package rs_adder_station_pkg;

  localparam int RS_DATA_W = 16;
  localparam int RS_TAG_W  = 5;
  localparam int RS_OP_W   = 2;

  localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } row_state_e;

  typedef struct packed {
    row_state_e            state;
    logic [RS_OP_W-1:0]    op;
    logic [RS_TAG_W-1:0]   qj;
    logic [RS_TAG_W-1:0]   qk;
    logic [RS_DATA_W-1:0]  vj;
    logic [RS_DATA_W-1:0]  vk;
  } rs_row_t;

  localparam rs_row_t ROW_RESET = '{state: ST_FREE, op: '0, qj: '0, qk: '0, vj: '0, vk: '0};

  // A pending operand (nonzero Q) is satisfied by a matching broadcast.
  function automatic logic tag_hit(input logic v, input logic [RS_TAG_W-1:0] q,
                                   input logic [RS_TAG_W-1:0] tag);
    return v && (q != TAG_NONE) && (q == tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_prio_pick.sv
`default_nettype none
// =============================================================================
// rs_prio_pick -- lowest-set-bit finder returning index and one-hot
// Rev 1.0
// =============================================================================
module rs_prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    found_o  = |req_i;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o    = IDX_W'(i);
        onehot_o = N'(1) << i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_adder_station.sv
`default_nettype none
// =============================================================================
// rs_adder_station -- adder reservation station with CDB capture and dispatch
// Define RS_OLDEST_FIRST_EN to dispatch the oldest READY row instead of lowest.
// Rev 1.0
// =============================================================================
module rs_adder_station
  import rs_adder_station_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_W      = RS_DATA_W,
  parameter int TAG_W       = RS_TAG_W,
  parameter int OP_W        = RS_OP_W,
  parameter int TAG_BASE    = 0
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [OP_W-1:0]        issue_op,
  input  logic [TAG_W-1:0]       issue_qj,
  input  logic [TAG_W-1:0]       issue_qk,
  input  logic [DATA_W-1:0]      issue_vj,
  input  logic [DATA_W-1:0]      issue_vk,
  output logic [TAG_W-1:0]       issue_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic [OP_W-1:0]        disp_op,
  output logic [DATA_W-1:0]      disp_vj,
  output logic [DATA_W-1:0]      disp_vk,
  output logic [TAG_W-1:0]       disp_tag,
  input  logic                   flush,
  output logic [NUM_ENTRIES-1:0] Busy,
  output logic                   full
);

  localparam int               IDX_W     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(TAG_BASE + 1);

  // Row storage widths come from the package record.
  rs_row_t rows_q [NUM_ENTRIES];
  rs_row_t rows_d [NUM_ENTRIES];

  logic              disp_valid_q, disp_valid_d;
  logic [IDX_W-1:0]  disp_idx_q,   disp_idx_d;
  logic [OP_W-1:0]   disp_op_q,    disp_op_d;
  logic [DATA_W-1:0] disp_vj_q,    disp_vj_d;
  logic [DATA_W-1:0] disp_vk_q,    disp_vk_d;
  logic [TAG_W-1:0]  disp_tag_q,   disp_tag_d;

  logic [NUM_ENTRIES-1:0] free_vec, ready_vec, ready_avail, disp_cand, cdb_free;
  logic [NUM_ENTRIES-1:0] free_oh, disp_oh;
  logic [IDX_W-1:0]       free_idx, disp_pick_idx;
  logic                   free_found, disp_found;
  logic                   issue_fire, disp_accept, disp_load;
  logic                   byp_j, byp_k;

  rs_prio_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_pick (
    .req_i    (free_vec),
    .found_o  (free_found),
    .idx_o    (free_idx),
    .onehot_o (free_oh)
  );

  rs_prio_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_disp_pick (
    .req_i    (disp_cand),
    .found_o  (disp_found),
    .idx_o    (disp_pick_idx),
    .onehot_o (disp_oh)
  );

  // Output / status decode from the registered row states.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      Busy[i]      = (rows_q[i].state != ST_FREE);
      ready_vec[i] = (rows_q[i].state == ST_READY);
      cdb_free[i]  = cdb_valid && (rows_q[i].state == ST_EXEC) &&
                     (cdb_tag == TAG_FIRST + TAG_W'(i));
    end
    free_vec    = ~Busy;
    ready_avail = ready_vec;
    if (disp_valid_q) ready_avail[disp_idx_q] = 1'b0;
  end

  assign full        = !free_found;
  assign issue_ready = !full && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_tag   = TAG_FIRST + TAG_W'(free_idx);
  assign disp_accept = disp_valid_q && disp_ready;
  assign disp_load   = (!disp_valid_q || disp_ready) && disp_found;
  assign byp_j       = tag_hit(cdb_valid, issue_qj, cdb_tag);
  assign byp_k       = tag_hit(cdb_valid, issue_qk, cdb_tag);

`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] age_q [NUM_ENTRIES];
  logic [IDX_W-1:0] age_d [NUM_ENTRIES];
  logic [IDX_W-1:0] freed_age;
  logic             freed_any;

  // Age = number of live rows issued after this one, so it never exceeds N-1.
  always_comb begin
    freed_any = |cdb_free;
    freed_age = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cdb_free[i]) freed_age = age_q[i];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (Busy[i] && !cdb_free[i]) begin
        if (issue_fire) age_d[i] = age_d[i] + IDX_W'(1);
        if (freed_any && (freed_age < age_q[i])) age_d[i] = age_d[i] - IDX_W'(1);
      end
      if (issue_fire && free_oh[i]) age_d[i] = '0;
      if (flush) age_d[i] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      disp_cand[i] = ready_avail[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (ready_avail[j] && (age_q[j] > age_q[i])) disp_cand[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign disp_cand = ready_avail;
`endif

  // Per-row next state.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rows_d[i] = rows_q[i];
      case (rows_q[i].state)
        ST_FREE: begin
          if (issue_fire && free_oh[i]) begin
            rows_d[i].op    = issue_op;
            rows_d[i].qj    = byp_j ? TAG_NONE : issue_qj;
            rows_d[i].vj    = byp_j ? cdb_data : issue_vj;
            rows_d[i].qk    = byp_k ? TAG_NONE : issue_qk;
            rows_d[i].vk    = byp_k ? cdb_data : issue_vk;
            rows_d[i].state = ((rows_d[i].qj == TAG_NONE) && (rows_d[i].qk == TAG_NONE)) ?
                              ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tag_hit(cdb_valid, rows_q[i].qj, cdb_tag)) begin
            rows_d[i].qj = TAG_NONE;
            rows_d[i].vj = cdb_data;
          end
          if (tag_hit(cdb_valid, rows_q[i].qk, cdb_tag)) begin
            rows_d[i].qk = TAG_NONE;
            rows_d[i].vk = cdb_data;
          end
          if ((rows_d[i].qj == TAG_NONE) && (rows_d[i].qk == TAG_NONE)) rows_d[i].state = ST_READY;
        end
        ST_READY: begin
          if (disp_accept && (disp_idx_q == IDX_W'(i))) rows_d[i].state = ST_EXEC;
        end
        ST_EXEC: begin
          if (cdb_free[i]) rows_d[i].state = ST_FREE;
        end
        default: ;
      endcase
      if (flush) rows_d[i].state = ST_FREE;
    end
  end

  // Dispatch slot: holds its row and payload until accepted.
  always_comb begin
    disp_valid_d = disp_valid_q;
    disp_idx_d   = disp_idx_q;
    disp_op_d    = disp_op_q;
    disp_vj_d    = disp_vj_q;
    disp_vk_d    = disp_vk_q;
    disp_tag_d   = disp_tag_q;
    if (disp_accept) disp_valid_d = 1'b0;
    if (disp_load) begin
      disp_valid_d = 1'b1;
      disp_idx_d   = disp_pick_idx;
      disp_tag_d   = TAG_FIRST + TAG_W'(disp_pick_idx);
      disp_op_d    = '0;
      disp_vj_d    = '0;
      disp_vk_d    = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (disp_oh[i]) begin
          disp_op_d = rows_q[i].op;
          disp_vj_d = rows_q[i].vj;
          disp_vk_d = rows_q[i].vk;
        end
      end
    end
    if (flush) disp_valid_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) rows_q[i] <= ROW_RESET;
      disp_valid_q <= 1'b0;
      disp_idx_q   <= '0;
      disp_op_q    <= '0;
      disp_vj_q    <= '0;
      disp_vk_q    <= '0;
      disp_tag_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) rows_q[i] <= rows_d[i];
      disp_valid_q <= disp_valid_d;
      disp_idx_q   <= disp_idx_d;
      disp_op_q    <= disp_op_d;
      disp_vj_q    <= disp_vj_d;
      disp_vk_q    <= disp_vk_d;
      disp_tag_q   <= disp_tag_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_op    = disp_op_q;
  assign disp_vj    = disp_vj_q;
  assign disp_vk    = disp_vk_q;
  assign disp_tag   = disp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_adder_station.sv
`default_nettype none
// =============================================================================
// tb_rs_adder_station -- directed vector table plus multi-cycle sequences
// Rev 1.0
// =============================================================================
module tb_rs_adder_station;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int TW = 5;
  localparam int OW = 2;
  localparam int NV = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid, issue_ready;
  logic [OW-1:0] issue_op;
  logic [TW-1:0] issue_qj, issue_qk, issue_tag;
  logic [DW-1:0] issue_vj, issue_vk;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          disp_valid, disp_ready;
  logic [OW-1:0] disp_op;
  logic [DW-1:0] disp_vj, disp_vk;
  logic [TW-1:0] disp_tag;
  logic          flush;
  logic [N-1:0]  Busy;
  logic          full;

  always #5 clk = ~clk;

  rs_adder_station #(
    .NUM_ENTRIES(N), .DATA_W(DW), .TAG_W(TW), .OP_W(OW), .TAG_BASE(0)
  ) dut (
    .Clock(clk), .Resetn(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
    .flush(flush), .Busy(Busy), .full(full)
  );

  typedef struct {
    logic          iv;
    logic [OW-1:0] op;
    logic [TW-1:0] qj, qk;
    logic [DW-1:0] vj, vk;
    logic          cv;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
    logic          dr, fl;
    logic [N-1:0]  busy;
    logic          dv, pl;
    logic [OW-1:0] dop;
    logic [TW-1:0] dtag;
    logic [DW-1:0] dvj, dvk;
  } vec_t;

  vec_t vt [NV];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int iv, int op, int qj, int qk, int vj, int vk,
                              int cv, int ct, int cd, int dr, int fl,
                              int busy, int dv, int pl, int dop, int dtag, int dvj, int dvk);
    vec_t v;
    v.iv = 1'(iv);   v.op = OW'(op);  v.qj = TW'(qj);  v.qk = TW'(qk);
    v.vj = DW'(vj);  v.vk = DW'(vk);  v.cv = 1'(cv);   v.ct = TW'(ct);
    v.cd = DW'(cd);  v.dr = 1'(dr);   v.fl = 1'(fl);   v.busy = N'(busy);
    v.dv = 1'(dv);   v.pl = 1'(pl);   v.dop = OW'(dop); v.dtag = TW'(dtag);
    v.dvj = DW'(dvj); v.dvk = DW'(dvk);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = '0; issue_qj = '0; issue_qk = '0;
    issue_vj = '0; issue_vk = '0; cdb_valid = 1'b0; cdb_tag = '0;
    cdb_data = '0; disp_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_op = v.op; issue_qj = v.qj; issue_qk = v.qk;
    issue_vj = v.vj; issue_vk = v.vk; cdb_valid = v.cv; cdb_tag = v.ct;
    cdb_data = v.cd; disp_ready = v.dr; flush = v.fl;
  endtask

  initial begin
    //            iv op qj qk vj    vk     cv ct cd     dr fl  busy  dv pl dop dtag dvj   dvk
    vt[0]  = mk(1, 1, 0, 0, 5,    7,     0, 0, 0,     0, 0,  'h01, 0, 0, 0, 0, 0,    0);
    vt[1]  = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     0, 0,  'h01, 1, 1, 1, 1, 5,    7);
    vt[2]  = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     1, 0,  'h01, 0, 0, 0, 0, 0,    0);
    vt[3]  = mk(0, 0, 0, 0, 0,    0,     1, 1, 'h99,  0, 0,  'h00, 0, 0, 0, 0, 0,    0);
    vt[4]  = mk(1, 2, 9, 0, 0,    'h11,  0, 0, 0,     0, 0,  'h01, 0, 0, 0, 0, 0,    0);
    vt[5]  = mk(1, 3, 0, 7, 1,    0,     0, 0, 0,     0, 0,  'h03, 0, 0, 0, 0, 0,    0);
    vt[6]  = mk(1, 0, 9, 0, 0,    'h22,  0, 0, 0,     0, 0,  'h07, 0, 0, 0, 0, 0,    0);
    vt[7]  = mk(0, 0, 0, 0, 0,    0,     1, 9, 'h33,  0, 0,  'h07, 0, 0, 0, 0, 0,    0);
    vt[8]  = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     0, 0,  'h07, 1, 1, 2, 1, 'h33, 'h11);
    vt[9]  = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     1, 0,  'h07, 1, 1, 0, 3, 'h33, 'h22);
    vt[10] = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     1, 0,  'h07, 0, 0, 0, 0, 0,    0);
    vt[11] = mk(1, 1, 0, 4, 'h10, 0,     1, 4, 'hAA,  0, 0,  'h0F, 0, 0, 0, 0, 0,    0);
    vt[12] = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     0, 0,  'h0F, 1, 1, 1, 4, 'h10, 'hAA);
    vt[13] = mk(0, 0, 0, 0, 0,    0,     1, 7, 'h44,  0, 0,  'h0F, 1, 1, 1, 4, 'h10, 'hAA);
    vt[14] = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     0, 0,  'h0F, 1, 1, 1, 4, 'h10, 'hAA);
    vt[15] = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     0, 0,  'h0F, 1, 1, 1, 4, 'h10, 'hAA);
    vt[16] = mk(0, 0, 0, 0, 0,    0,     0, 0, 0,     1, 0,  'h0F, 1, 1, 3, 2, 1,    'h44);
    vt[17] = mk(0, 0, 0, 0, 0,    0,     1, 4, 0,     0, 0,  'h07, 1, 1, 3, 2, 1,    'h44);
    vt[18] = mk(0, 0, 0, 0, 0,    0,     1, 0, 'h12,  0, 0,  'h07, 1, 1, 3, 2, 1,    'h44);
    vt[19] = mk(0, 0, 0, 0, 0,    0,     1, 9, 'h12,  0, 0,  'h07, 1, 1, 3, 2, 1,    'h44);
    vt[20] = mk(0, 0, 0, 0, 0,    0,     1, 3, 0,     0, 0,  'h03, 1, 1, 3, 2, 1,    'h44);
    vt[21] = mk(1, 1, 0, 0, 0,    0,     1, 1, 0,     1, 1,  'h00, 0, 0, 0, 0, 0,    0);

    // Reset state
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst busy",        32'(Busy),        32'h0);
    check("rst full",        32'(full),        32'h0);
    check("rst disp_valid",  32'(disp_valid),  32'h0);
    check("rst issue_ready", 32'(issue_ready), 32'h1);
    check("rst issue_tag",   32'(issue_tag),   32'h1);
    check("rst disp_vj",     32'(disp_vj),     32'h0);

    // Vector table: inputs held across one edge, outputs checked just after it
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vt[k]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy", k),       32'(Busy),       32'(vt[k].busy));
      check($sformatf("v%0d disp_valid", k), 32'(disp_valid), 32'(vt[k].dv));
      if (vt[k].pl) begin
        check($sformatf("v%0d disp_op", k),  32'(disp_op),  32'(vt[k].dop));
        check($sformatf("v%0d disp_tag", k), 32'(disp_tag), 32'(vt[k].dtag));
        check($sformatf("v%0d disp_vj", k),  32'(disp_vj),  32'(vt[k].dvj));
        check($sformatf("v%0d disp_vk", k),  32'(disp_vk),  32'(vt[k].dvk));
      end
    end
    @(negedge clk);
    idle();

    // Fill all rows waiting on an unresolved tag
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check($sformatf("fill%0d issue_tag", i), 32'(issue_tag), 32'(i + 1));
      issue_valid = 1'b1; issue_op = 2'd1; issue_qj = 5'd9; issue_qk = '0;
      issue_vj = '0; issue_vk = 16'(i);
    end
    @(negedge clk);
    check("full flag",        32'(full),        32'h1);
    check("full issue_ready", 32'(issue_ready), 32'h0);
    check("full busy",        32'(Busy),        32'hFF);
    @(negedge clk);
    issue_valid = 1'b0;
    check("ninth rejected busy", 32'(Busy), 32'hFF);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 16'h55;
    @(negedge clk);
    cdb_valid = 1'b0;
    @(negedge clk);
    check("full disp_valid", 32'(disp_valid), 32'h1);
    check("full disp_tag",   32'(disp_tag),   32'h1);
    check("full disp_vj",    32'(disp_vj),    32'h55);
    disp_ready = 1'b1;
    @(negedge clk);
    check("b2b disp_tag", 32'(disp_tag), 32'h2);
    check("b2b disp_vk",  32'(disp_vk),  32'h1);
    // Free row 0 while an issue is offered: the freed row is not reusable yet
    disp_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_data = '0;
    issue_valid = 1'b1; issue_qj = '0; issue_qk = '0;
    #1;
    check("free cycle issue_ready", 32'(issue_ready), 32'h0);
    @(negedge clk);
    idle();
    check("freed busy",        32'(Busy),        32'hFE);
    check("freed full",        32'(full),        32'h0);
    check("freed issue_ready", 32'(issue_ready), 32'h1);
    check("freed issue_tag",   32'(issue_tag),   32'h1);
    flush = 1'b1;
    #1;
    check("flush issue_ready", 32'(issue_ready), 32'h0);
    @(negedge clk);
    idle();
    check("flush busy",       32'(Busy),       32'h0);
    check("flush disp_valid", 32'(disp_valid), 32'h0);

    // Reset asserted mid-cycle while a dispatch is pending
    issue_valid = 1'b1; issue_op = 2'd2; issue_vj = 16'h77; issue_vk = 16'h88;
    @(negedge clk);
    idle();
    @(negedge clk);
    check("pre-rst disp_valid", 32'(disp_valid), 32'h1);
    check("pre-rst disp_vj",    32'(disp_vj),    32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst disp_valid", 32'(disp_valid), 32'h0);
    check("async rst busy",       32'(Busy),       32'h0);
    check("async rst disp_vj",    32'(disp_vj),    32'h0);
    check("async rst disp_tag",   32'(disp_tag),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    disp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst disp_valid", 32'(disp_valid), 32'h0);
    check("post-rst busy",       32'(Busy),       32'h0);
    check("post-rst issue_tag",  32'(issue_tag),  32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
